// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite renderer and its animation sequencer.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } anim_state_t;

    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int TRANSP_DEFAULT = 0;

endpackage

// File: rtl/sprite_anim_seq.sv
// Animation sequencer: steps the sprite frame every (anim_rate+1) frame_ticks, looping or one-shot.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int FRAMES = 4,
    parameter int RATE_W = 4,
    localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              anim_start,
    input  logic              anim_loop,
    input  logic [RATE_W-1:0] anim_rate,
    output logic [FW-1:0]     anim_frame,
    output logic              anim_done,
    output anim_state_t       anim_state
);

    localparam logic [FW-1:0] LAST = FW'(FRAMES - 1);

    anim_state_t       state_n;
    logic [FW-1:0]     frame_n;
    logic [RATE_W-1:0] cnt, cnt_n;
    logic              done_n;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            anim_state <= IDLE;
            anim_frame <= '0;
            cnt        <= '0;
            anim_done  <= 1'b0;
        end else begin
            anim_state <= state_n;
            anim_frame <= frame_n;
            cnt        <= cnt_n;
            anim_done  <= done_n;
        end
    end

    // anim_start overrides everything, including a coincident tick.
    always_comb begin
        state_n = anim_state;
        frame_n = anim_frame;
        cnt_n   = cnt;
        done_n  = 1'b0;
        if (anim_start) begin
            state_n = PLAY;
            frame_n = '0;
            cnt_n   = '0;
        end else if (anim_state == PLAY && frame_tick) begin
            if (cnt != anim_rate) begin
                cnt_n = cnt + 1'b1;
            end else begin
                cnt_n = '0;
                if (anim_frame == LAST) begin
                    if (anim_loop) begin
                        frame_n = '0;
                    end else begin
                        state_n = HOLD;
                        done_n  = 1'b1;
                    end
                end else begin
                    frame_n = anim_frame + 1'b1;
                    if (!anim_loop && frame_n == LAST) begin
                        state_n = HOLD;
                        done_n  = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sprite_anim_renderer.sv
// Sprite pixel generator: 3-stage pipeline from DrawX/DrawY to palette index and opaque-hit flag.
module sprite_anim_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 64,
    parameter int FRAMES     = 4,
    parameter int SCALE_SH   = 1,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = TRANSP_DEFAULT,
    parameter int RATE_W     = 4,
    localparam int AW        = $clog2(FRAMES * SPR_W * SPR_H),
    localparam int FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip,
    input  logic              frame_tick,
    input  logic              anim_start,
    input  logic              anim_loop,
    input  logic [RATE_W-1:0] anim_rate,
    output logic [AW-1:0]     rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_hit,
    output logic [FW-1:0]     anim_frame,
    output logic              anim_done,
    output anim_state_t       anim_state
);

    localparam int LXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int LYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    sprite_anim_seq #(.FRAMES(FRAMES), .RATE_W(RATE_W)) u_seq (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .anim_start (anim_start),
        .anim_loop  (anim_loop),
        .anim_rate  (anim_rate),
        .anim_frame (anim_frame),
        .anim_done  (anim_done),
        .anim_state (anim_state)
    );

    // Unsigned subtraction at 11 bits: bit 10 set means the pixel is left of / above the sprite.
    logic [10:0] dx, dy;
    logic        inside_c;
    assign dx = {1'b0, DrawX} - {1'b0, sprite_x};
    assign dy = {1'b0, DrawY} - {1'b0, sprite_y};
    assign inside_c = !dx[10] && !dy[10]
                   && (({1'b0, dx[9:0]} >> SCALE_SH) < 11'(SPR_W))
                   && (({1'b0, dy[9:0]} >> SCALE_SH) < 11'(SPR_H));

    logic [9:0]    dx_s1, dy_s1;
    logic          inside_s1, blank_s1, flip_s1;
    logic [FW-1:0] frame_s1;

    // frame_s1 only moves on frame_tick so one scan always reads a single frame.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            dx_s1     <= '0;
            dy_s1     <= '0;
            inside_s1 <= 1'b0;
            blank_s1  <= 1'b0;
            flip_s1   <= 1'b0;
            frame_s1  <= '0;
        end else begin
            dx_s1     <= dx[9:0];
            dy_s1     <= dy[9:0];
            inside_s1 <= inside_c;
            blank_s1  <= blank;
            flip_s1   <= flip;
            if (frame_tick) frame_s1 <= anim_frame;
        end
    end

    logic [LXW-1:0] lx, lxf;
    logic [LYW-1:0] ly;
    logic [AW-1:0]  addr_c;
    assign lx  = LXW'(dx_s1 >> SCALE_SH);
    assign ly  = LYW'(dy_s1 >> SCALE_SH);
    assign lxf = flip_s1 ? (LXW'(SPR_W - 1) - lx) : lx;
    assign addr_c = AW'(frame_s1) * AW'(SPR_W * SPR_H) + AW'(ly) * AW'(SPR_W) + AW'(lxf);

    logic inside_s2, blank_s2;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_address <= '0;
            inside_s2   <= 1'b0;
            blank_s2    <= 1'b0;
            pix_idx     <= '0;
            pix_hit     <= 1'b0;
        end else begin
            if (inside_s1) rom_address <= addr_c;
            inside_s2 <= inside_s1;
            blank_s2  <= blank_s1;
            pix_idx   <= rom_q;
            pix_hit   <= inside_s2 & blank_s2 & (rom_q != IDX_W'(TRANSP_IDX));
        end
    end

endmodule
